pipeline_stage_decode: RTL and testbench

PIPELINE_STAGE_DECODE -- requirements
Module: pipeline_stage_decode

---
 rtl/pipeline_stage_decode.sv | 169 ++++++++++++++++
 tb/tb_pipeline_stage_decode.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_decode.sv
// pipeline_stage_decode
//
// Decode stage of a short in-order pipeline. It owns the architectural
// register file. It takes the instruction held in the fetch result register,
// reads its operands with a same-cycle writeback bypass, and hands a
// registered payload to the execute stage.
//
// Instructions are squashed when they belong to a stale PC epoch, when they
// arrive before the stage is primed after reset, or when execute redirects
// the PC in the same cycle. A load-use dependency on the instruction currently
// in execute stalls fetch for one cycle and injects a bubble.
//
// Ports
//   clock, reset          rising-edge clock; synchronous active-high reset
//   fetch_pc/epoch/op     instruction from fetch: PC, PC-change parity, opcode
//   fetch_rs/rt/rd        source/source/destination register indices
//   fetch_uses_rs/rt      operand-use flags for hazard detection
//   fetch_writes_reg      instruction writes rd
//   fetch_is_load         instruction is a load
//   fetch_imm             sign-extended immediate
//   jump_enabled          execute redirects the PC this cycle
//   wb_enable/addr/data   register file write port
//   stall_on_decode       combinational; fetch holds PC and result register
//   dec_*                 registered payload to execute; dec_valid marks a
//                         real instruction, otherwise the payload is a bubble

module pipeline_stage_decode #(
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] fetch_pc,
    input  logic        fetch_epoch,
    input  logic [5:0]  fetch_op,
    input  logic [4:0]  fetch_rs,
    input  logic [4:0]  fetch_rt,
    input  logic [4:0]  fetch_rd,
    input  logic        fetch_uses_rs,
    input  logic        fetch_uses_rt,
    input  logic        fetch_writes_reg,
    input  logic        fetch_is_load,
    input  logic [31:0] fetch_imm,

    input  logic        jump_enabled,

    input  logic        wb_enable,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,

    output logic        stall_on_decode,

    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [5:0]  dec_op,
    output logic [4:0]  dec_rd,
    output logic        dec_writes_reg,
    output logic        dec_is_load,
    output logic [31:0] dec_imm,
    output logic [31:0] dec_rs_value,
    output logic [31:0] dec_rt_value
);

    // ------------------------------------------------------------------
    // Register file (deliberately not cleared by reset)
    // ------------------------------------------------------------------
    logic [31:0] regs [32];
    logic        wb_commit;

    assign wb_commit = wb_enable && !(ZERO_REG_HARDWIRED && (wb_addr == 5'd0));

    always_ff @(posedge clock) begin
        if (wb_commit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Operand reads. A write landing on the same edge is bypassed so the
    // payload captured at that edge already carries the new value.
    logic [31:0] rs_value;
    logic [31:0] rt_value;

    always_comb begin
        rs_value = regs[fetch_rs];
        if (ZERO_REG_HARDWIRED && (fetch_rs == 5'd0)) begin
            rs_value = '0;
        end else if (wb_enable && (wb_addr == fetch_rs) && (fetch_rs != 5'd0)) begin
            rs_value = wb_data;
        end
    end

    always_comb begin
        rt_value = regs[fetch_rt];
        if (ZERO_REG_HARDWIRED && (fetch_rt == 5'd0)) begin
            rt_value = '0;
        end else if (wb_enable && (wb_addr == fetch_rt) && (fetch_rt != 5'd0)) begin
            rt_value = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Epoch and primed tracking
    // ------------------------------------------------------------------
    logic epoch;
    logic primed;

    always_ff @(posedge clock) begin
        if (reset) begin
            epoch  <= 1'b0;
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
            if (jump_enabled) begin
                epoch <= ~epoch;
            end
        end
    end

    // ------------------------------------------------------------------
    // Liveness and load-use hazard
    // ------------------------------------------------------------------
    logic live;
    logic rs_hit;
    logic rt_hit;
    logic hazard;

    assign live   = primed && (fetch_epoch == epoch) && !jump_enabled;

    assign rs_hit = fetch_uses_rs && (fetch_rs == dec_rd);
    assign rt_hit = fetch_uses_rt && (fetch_rt == dec_rd);

    // The bubble injected by a stall clears dec_is_load, so a given hazard
    // can hold fetch for one cycle only.
    assign hazard = dec_valid && dec_is_load && dec_writes_reg &&
                    (dec_rd != 5'd0) && (rs_hit || rt_hit);

    assign stall_on_decode = live && hazard && !jump_enabled && !reset;

    logic issue;
    assign issue = live && !hazard;

    // ------------------------------------------------------------------
    // Execute payload register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset || !issue) begin
            dec_valid      <= 1'b0;
            dec_pc         <= '0;
            dec_op         <= '0;
            dec_rd         <= '0;
            dec_writes_reg <= 1'b0;
            dec_is_load    <= 1'b0;
            dec_imm        <= '0;
            dec_rs_value   <= '0;
            dec_rt_value   <= '0;
        end else begin
            dec_valid      <= 1'b1;
            dec_pc         <= fetch_pc;
            dec_op         <= fetch_op;
            dec_rd         <= fetch_rd;
            dec_writes_reg <= fetch_writes_reg;
            dec_is_load    <= fetch_is_load;
            dec_imm        <= fetch_imm;
            dec_rs_value   <= rs_value;
            dec_rt_value   <= rt_value;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_decode.sv
// Directed bench for pipeline_stage_decode. Each step drives fetch and
// writeback inputs, checks stall_on_decode, and queues the expected execute
// payload. That payload is popped and compared after the next rising edge.

module tb_pipeline_stage_decode;

    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_LW  = 6'h23;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic [31:0] imm;
        logic [31:0] rsv;
        logic [31:0] rtv;
    } dec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        fetch_epoch;
    logic [5:0]  fetch_op;
    logic [4:0]  fetch_rs, fetch_rt, fetch_rd;
    logic        fetch_uses_rs, fetch_uses_rt, fetch_writes_reg, fetch_is_load;
    logic [31:0] fetch_imm;
    logic        jump_enabled;
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_on_decode;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [5:0]  dec_op;
    logic [4:0]  dec_rd;
    logic        dec_writes_reg, dec_is_load;
    logic [31:0] dec_imm, dec_rs_value, dec_rt_value;

    int unsigned checks = 0;
    int unsigned fails  = 0;
    dec_t        sb_q[$];
    dec_t        got, want;

    pipeline_stage_decode #(.ZERO_REG_HARDWIRED(1'b1)) dut (
        .clock(clock), .reset(reset),
        .fetch_pc(fetch_pc), .fetch_epoch(fetch_epoch), .fetch_op(fetch_op),
        .fetch_rs(fetch_rs), .fetch_rt(fetch_rt), .fetch_rd(fetch_rd),
        .fetch_uses_rs(fetch_uses_rs), .fetch_uses_rt(fetch_uses_rt),
        .fetch_writes_reg(fetch_writes_reg), .fetch_is_load(fetch_is_load),
        .fetch_imm(fetch_imm), .jump_enabled(jump_enabled),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_on_decode(stall_on_decode),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_op(dec_op), .dec_rd(dec_rd),
        .dec_writes_reg(dec_writes_reg), .dec_is_load(dec_is_load),
        .dec_imm(dec_imm), .dec_rs_value(dec_rs_value), .dec_rt_value(dec_rt_value)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic dec_t mk(input logic [31:0] pc, input logic [5:0] op,
                                input logic [4:0] rd, input logic ld,
                                input logic [31:0] imm, input logic [31:0] rsv,
                                input logic [31:0] rtv);
        dec_t d;
        d.valid = 1'b1; d.pc = pc; d.op = op; d.rd = rd; d.wr = 1'b1;
        d.ld = ld; d.imm = imm; d.rsv = rsv; d.rtv = rtv;
        return d;
    endfunction

    task automatic fetch(input logic [31:0] pc, input logic ep, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt, input logic ld,
                         input logic [31:0] imm);
        fetch_pc = pc; fetch_epoch = ep; fetch_op = op;
        fetch_rs = rs; fetch_rt = rt; fetch_rd = rd;
        fetch_uses_rs = urs; fetch_uses_rt = urt;
        fetch_writes_reg = 1'b1; fetch_is_load = ld; fetch_imm = imm;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_enable = en; wb_addr = a; wb_data = d;
    endtask

    task automatic check_stall(input string tag, input logic exp_stall);
        checks++;
        assert (stall_on_decode === exp_stall) else begin
            fails++;
            $error("FAIL %s stall: observed %b expected %b", tag, stall_on_decode, exp_stall);
        end
    endtask

    // Check stall for the inputs just driven, queue the expected payload,
    // clock once, then compare the registered payload.
    task automatic tick(input string tag, input logic exp_stall, input dec_t exp_dec);
        #1;
        check_stall(tag, exp_stall);
        sb_q.push_back(exp_dec);
        @(posedge clock);
        #1;
        want = sb_q.pop_front();
        got  = {dec_valid, dec_pc, dec_op, dec_rd, dec_writes_reg, dec_is_load,
                dec_imm, dec_rs_value, dec_rt_value};
        checks++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s dec: observed %h expected %h", tag, got, want);
        end
    endtask

    initial begin
        reset = 1'b1;
        jump_enabled = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        fetch(32'h10, 1'b0, OP_ADD, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 32'd0);
        @(posedge clock); #1;
        tick("reset", 1'b0, '0);

        // First post-reset fetch is ignored (unprimed); preload registers.
        reset = 1'b0;
        wb(1'b1, 5'd1, 32'd5);
        tick("unprimed", 1'b0, '0);

        fetch(32'h14, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 32'd0);
        wb(1'b1, 5'd2, 32'd7);
        tick("stale_epoch_a", 1'b0, '0);
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick("stale_epoch_b", 1'b0, '0);

        wb(1'b0, 5'd0, 32'd0);
        fetch(32'h10, 1'b0, OP_ADD, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 32'd0);
        tick("add_basic", 1'b0, mk(32'h10, OP_ADD, 5'd5, 1'b0, 32'd0, 32'd5, 32'd7));

        // Load of r3, then a dependent ADD: one stall cycle with a writeback
        // to r3 landing during the stall.
        fetch(32'h14, 1'b0, OP_LW, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 32'd4);
        tick("lw_r3", 1'b0, mk(32'h14, OP_LW, 5'd3, 1'b1, 32'd4, 32'd5, 32'd0));
        fetch(32'h18, 1'b0, OP_ADD, 5'd3, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 32'd0);
        wb(1'b1, 5'd3, 32'h99);
        tick("load_use_stall", 1'b1, '0);
        wb(1'b0, 5'd0, 32'd0);
        tick("load_use_retry", 1'b0, mk(32'h18, OP_ADD, 5'd6, 1'b0, 32'd0, 32'h99, 32'd7));

        // Same-cycle bypass.
        fetch(32'h1C, 1'b0, OP_ADD, 5'd4, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0);
        wb(1'b1, 5'd4, 32'hDEAD_BEEF);
        tick("bypass_r4", 1'b0, mk(32'h1C, OP_ADD, 5'd7, 1'b0, 32'd0, 32'hDEAD_BEEF, 32'd5));

        // r0 stays zero even with a concurrent write to it.
        fetch(32'h20, 1'b0, OP_ADD, 5'd0, 5'd4, 5'd8, 1'b1, 1'b1, 1'b0, 32'd0);
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick("r0_zero", 1'b0, mk(32'h20, OP_ADD, 5'd8, 1'b0, 32'd0, 32'd0, 32'hDEAD_BEEF));
        wb(1'b0, 5'd0, 32'd0);

        // Jump coinciding with a load-use hazard: jump wins.
        fetch(32'h24, 1'b0, OP_LW, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 32'd8);
        tick("lw_r9", 1'b0, mk(32'h24, OP_LW, 5'd9, 1'b1, 32'd8, 32'd5, 32'd0));
        fetch(32'h28, 1'b0, OP_ADD, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 32'd0);
        jump_enabled = 1'b1;
        tick("jump_over_hazard", 1'b0, '0);
        jump_enabled = 1'b0;
        fetch(32'h2C, 1'b0, OP_ADD, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 32'd0);
        tick("old_epoch_squash", 1'b0, '0);
        fetch(32'h40, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 1'b0, 32'd0);
        tick("new_epoch_issue", 1'b0, mk(32'h40, OP_ADD, 5'd11, 1'b0, 32'd0, 32'd5, 32'd7));

        // Reset asserted in the middle of a load-use stall.
        fetch(32'h44, 1'b1, OP_LW, 5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 32'd0);
        tick("lw_r12", 1'b0, mk(32'h44, OP_LW, 5'd12, 1'b1, 32'd0, 32'd5, 32'd0));
        fetch(32'h48, 1'b1, OP_ADD, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 32'd0);
        #1;
        check_stall("pre_reset_stall", 1'b1);
        reset = 1'b1;
        tick("reset_mid_stall", 1'b0, '0);

        reset = 1'b0;
        fetch(32'h50, 1'b0, OP_ADD, 5'd1, 5'd2, 5'd14, 1'b1, 1'b1, 1'b0, 32'd0);
        tick("post_reset_unprimed", 1'b0, '0);
        tick("post_reset_issue", 1'b0, mk(32'h50, OP_ADD, 5'd14, 1'b0, 32'd0, 32'd5, 32'd7));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
